// File: rtl/histogram_cdf_reader.sv
// Sweeps the 256-bin histogram RAM after each frame and streams one beat per bin
// carrying the bin count, the running CDF and the histogram-equalisation level.
module histogram_cdf_reader #(
  parameter int BIN_W       = 16,
  parameter int CDF_W       = 24,
  parameter int LOG2_PIXELS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hist_valid,
  output logic [7:0]       hist_addr_rd,
  input  logic [BIN_W-1:0] hist_data_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_bin,
  output logic [BIN_W-1:0] out_count,
  output logic [CDF_W-1:0] out_cdf,
  output logic [7:0]       out_eq,
  output logic             out_last,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN} state_t;

  typedef struct packed {
    logic [7:0]       bin;
    logic [BIN_W-1:0] count;
    logic [CDF_W-1:0] cdf;
    logic [7:0]       eq;
    logic             last;
  } beat_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_addr;
  logic [7:0]       r_rd_bin;
  logic             r_inflight;
  logic [CDF_W-1:0] r_acc;
  beat_t            r_out, r_skid;
  logic             r_out_valid, r_skid_valid;
  logic             r_overrun;

  logic             w_hs, w_start, w_issue;
  logic [1:0]       w_occ;
  logic [CDF_W-1:0] w_sum;
  logic [CDF_W+7:0] w_prod, w_shift;
  logic [7:0]       w_eq;
  beat_t            w_in;

  assign w_hs    = r_out_valid & out_ready;
  assign w_start = hist_valid & (r_state == S_IDLE);

  // Beats held or in flight once this cycle's handshake retires; at most two keeps the skid sufficient.
  assign w_occ   = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_inflight) - 2'(w_hs);
  assign w_issue = (r_state == S_SWEEP) && (w_occ < 2'd2);

  assign w_sum   = r_acc + CDF_W'(hist_data_rd);
  assign w_prod  = (CDF_W+8)'(w_sum) * (CDF_W+8)'(255);
  assign w_shift = w_prod >> LOG2_PIXELS;
  assign w_eq    = (w_shift > (CDF_W+8)'(255)) ? 8'hFF : w_shift[7:0];

  assign w_in = '{bin: r_rd_bin, count: hist_data_rd, cdf: w_sum, eq: w_eq,
                  last: (r_rd_bin == 8'hFF)};

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (hist_valid) w_state_nxt = S_SWEEP;
      S_SWEEP: if (w_issue && (r_addr == 8'hFF)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_hs && r_out.last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rd_bin   <= '0;
      r_inflight <= 1'b0;
      r_acc      <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_start) begin
        r_addr    <= '0;
        r_acc     <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (w_issue && (r_addr != 8'hFF)) r_addr <= r_addr + 8'd1;
        if (r_inflight) r_acc <= w_sum;
        if (hist_valid) r_overrun <= 1'b1;
      end
      if (w_issue) r_rd_bin <= r_addr;
    end
  end

  // Output register with a one-entry skid behind it; the skid only fills while the output is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_hs) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= r_inflight;
        if (r_inflight) r_skid <= w_in;
      end else if (r_inflight) begin
        r_out       <= w_in;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (r_inflight) begin
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
    end
  end

  assign hist_addr_rd = r_addr;
  assign out_valid    = r_out_valid;
  assign out_bin      = r_out.bin;
  assign out_count    = r_out.count;
  assign out_cdf      = r_out.cdf;
  assign out_eq       = r_out.eq;
  assign out_last     = r_out.last;
  assign busy         = (r_state != S_IDLE);
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_histogram_cdf_reader.sv
// Scoreboard bench for histogram_cdf_reader: a RAM model feeds the DUT, expected beats
// come from a plain-arithmetic CDF/equalisation model, and a monitor compares each accepted beat.
module tb_histogram_cdf_reader;

  localparam int BIN_W = 16;
  localparam int CDF_W = 24;
  localparam int L2    = 16;

  typedef struct packed {
    logic [7:0]       bin;
    logic [BIN_W-1:0] count;
    logic [CDF_W-1:0] cdf;
    logic [7:0]       eq;
    logic             last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             hist_valid = 1'b0;
  logic [7:0]       hist_addr_rd;
  logic [BIN_W-1:0] hist_data_rd;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_bin;
  logic [BIN_W-1:0] out_count;
  logic [CDF_W-1:0] out_cdf;
  logic [7:0]       out_eq;
  logic             out_last;
  logic             busy;
  logic             overrun;

  logic [BIN_W-1:0] mem [256];
  beat_t            exp_q[$];
  int               n_cmp = 0;
  int               n_fail = 0;
  int               ready_mode = 0;  // 0: always ready, 1: random ~50%, 2: never ready

  histogram_cdf_reader #(.BIN_W(BIN_W), .CDF_W(CDF_W), .LOG2_PIXELS(L2)) dut (
    .clk(clk), .rst(rst), .hist_valid(hist_valid), .hist_addr_rd(hist_addr_rd),
    .hist_data_rd(hist_data_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_count(out_count), .out_cdf(out_cdf), .out_eq(out_eq),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Histogram RAM with one cycle of read latency.
  always @(posedge clk) hist_data_rd <= mem[hist_addr_rd];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: CDF is the running sum of bins, eq = min(255, floor(cdf*255 / 2^L2)).
  task automatic push_sweep();
    longint cdf = 0;
    longint eqv;
    beat_t  b;
    for (int k = 0; k < 256; k++) begin
      cdf += longint'(mem[k]);
      eqv = (cdf * 255) / (longint'(1) << L2);
      if (eqv > 255) eqv = 255;
      b.bin   = 8'(k);
      b.count = mem[k];
      b.cdf   = CDF_W'(cdf);
      b.eq    = 8'(eqv);
      b.last  = (k == 255);
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_hv();
    @(posedge clk); #1 hist_valid = 1'b1;
    @(posedge clk); #1 hist_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_done"}, 64'(t < 3000), 64'd1);
  endtask

  task automatic wait_beats(input int n, input string name);
    int seen = 0;
    int t = 0;
    while (seen < n && t < 3000) begin
      @(negedge clk);
      t++;
      if (out_valid && out_ready) seen++;
    end
    check({name, "_reach"}, 64'(seen), 64'(n));
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares accepted beats, payload stability under stall, and read-ahead bound.
  initial begin
    int    accepted = 0;
    bit    prev_stall = 1'b0;
    beat_t prev_beat = '0;
    beat_t cur;
    int    bound;
    forever begin
      @(negedge clk);
      cur = {out_bin, out_count, out_cdf, out_eq, out_last};
      if (!rst) begin
        accepted   = 0;
        prev_stall = 1'b0;
      end else begin
        if (busy) begin
          bound = (accepted + 2 > 255) ? 255 : accepted + 2;
          check("read_ahead", 64'(int'(hist_addr_rd) <= bound), 64'd1);
        end
        if (prev_stall) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_payload", 64'(cur), 64'(prev_beat));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_beat", 64'(cur), 64'd0);
          else check("beat", 64'(cur), 64'(exp_q.pop_front()));
          accepted = out_last ? 0 : accepted + 1;
        end
        prev_stall = out_valid && !out_ready;
        prev_beat  = cur;
      end
    end
  end

  initial begin
    int cnt;
    for (int k = 0; k < 256; k++) mem[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_addr", 64'(hist_addr_rd), 64'd0);
    check("rst_last_cdf", 64'({out_last, out_cdf}), 64'd0);
    rst = 1'b1;

    // Ramp with out_ready=1: latency and back-to-back beats.
    for (int k = 0; k < 256; k++) mem[k] = BIN_W'(k);
    ready_mode = 0;
    push_sweep();
    pulse_hv();
    check("start_busy", 64'(busy), 64'd1);
    check("start_addr", 64'(hist_addr_rd), 64'd0);
    @(posedge clk); #1;
    check("lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_first", 64'({out_valid, out_bin}), 64'({1'b1, 8'd0}));
    cnt = 0;
    for (int i = 0; i < 255; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("b2b_beats", 64'(cnt), 64'd255);
    check("b2b_last", 64'({out_last, out_bin}), 64'({1'b1, 8'd255}));
    @(posedge clk); #1;
    check("ramp_end_valid", 64'(out_valid), 64'd0);
    check("ramp_end_busy", 64'(busy), 64'd0);
    wait_done("ramp");

    // Flat histogram.
    for (int k = 0; k < 256; k++) mem[k] = BIN_W'(256);
    push_sweep();
    pulse_hv();
    wait_done("flat");

    // Saturating equalisation.
    for (int k = 0; k < 256; k++) mem[k] = (k < 2) ? 16'hFFFF : 16'h0;
    push_sweep();
    pulse_hv();
    wait_done("sat");

    // Ramp under random backpressure.
    for (int k = 0; k < 256; k++) mem[k] = BIN_W'(k);
    ready_mode = 1;
    push_sweep();
    pulse_hv();
    wait_done("bp");

    // Never ready: address counter stalls with two beats held.
    ready_mode = 2;
    push_sweep();
    pulse_hv();
    repeat (30) @(posedge clk);
    #1;
    check("stall_addr", 64'(hist_addr_rd), 64'd2);
    check("stall_head", 64'({out_valid, out_bin}), 64'({1'b1, 8'd0}));
    ready_mode = 1;
    wait_done("stall");

    // Overrun: second start at beat 100 is ignored.
    for (int k = 0; k < 256; k++) mem[k] = BIN_W'($urandom_range(0, 65535));
    ready_mode = 0;
    push_sweep();
    pulse_hv();
    wait_beats(100, "ovr");
    hist_valid = 1'b1;
    @(posedge clk); #1 hist_valid = 1'b0;
    check("ovr_set", 64'({overrun, busy}), 64'b11);
    wait_done("ovr");
    check("ovr_sticky", 64'(overrun), 64'd1);
    for (int k = 0; k < 256; k++) mem[k] = BIN_W'($urandom_range(0, 300));
    push_sweep();
    pulse_hv();
    check("ovr_clear", 64'(overrun), 64'd0);
    wait_done("ovr2");

    // hist_valid coincident with the out_last handshake.
    push_sweep();
    pulse_hv();
    cnt = 0;
    while (!(out_valid && out_ready && out_last) && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    check("coin_reach", 64'(cnt < 3000), 64'd1);
    hist_valid = 1'b1;
    @(posedge clk); #1 hist_valid = 1'b0;
    check("coin_ignored", 64'({busy, overrun}), 64'b01);
    repeat (5) @(posedge clk);
    #1;
    check("coin_idle", 64'({busy, out_valid}), 64'b00);

    // Reset mid-sweep, then a clean sweep.
    for (int k = 0; k < 256; k++) mem[k] = BIN_W'($urandom_range(0, 65535));
    ready_mode = 1;
    push_sweep();
    pulse_hv();
    wait_beats(50, "mid");
    #1 rst = 1'b0;
    #1;
    check("mid_rst", 64'({out_valid, busy}), 64'b00);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 256; k++) mem[k] = BIN_W'($urandom_range(0, 65535));
    push_sweep();
    pulse_hv();
    wait_done("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
